seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle restoring divider; inverse of the Wallace-tree multiplier.
- Takes a 2*WIDTH-bit dividend (multiplier product width) and a WIDTH-bit divisor.
- Returns a WIDTH-bit quotient and remainder, one quotient bit per clock.
- Sits alongside the multiplier in the arithmetic datapath; result bus can loop back as the dividend for multiply/divide round-trip checking.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Run  input  1  start request; sampled only in IDLE.
- Dividend  input  2*WIDTH  captured on the accepting edge.
- Divisor  input  WIDTH  captured on the accepting edge.
- Quotient  output  WIDTH  result; holds until next accepted Run.
- Remainder  output  WIDTH  result; holds until next accepted Run.
- Busy  output  1  high from the accepting edge through the DONE cycle.
- Done  output  1  single-cycle pulse; results valid.
- DivZero  output  1  divisor was zero; valid with Done, held until next accept.
- Overflow  output  1  quotient does not fit WIDTH bits; valid with Done, held until next accept.

Behaviour:
- Reset low (async): state IDLE; all outputs 0; internal regs 0. Reset asserted mid-divide aborts immediately; no Done is produced.
- States: IDLE, DIVIDE, DONE.
- IDLE:
  - Run=1 at edge E0 captures the operands and sets Busy=1.
  - Divisor==0 -> DONE, DivZero=1, Quotient=all ones, Remainder=Dividend[WIDTH-1:0].
  - Else Dividend[2W-1:W] >= Divisor -> DONE, Overflow=1, same Quotient/Remainder fill.
  - Else -> DIVIDE with R=Dividend[2W-1:W] (WIDTH+1-bit), Q=Dividend[W-1:0], count=0.
- DIVIDE, each edge:
  - T={R[W-1:0],Q[W-1]}.
  - If T>=Divisor: R=T-Divisor, Q={Q[W-2:0],1}; else R=T, Q={Q[W-2:0],0}.
  - count++. After WIDTH iterations (edge E_WIDTH), latch Quotient=Q and Remainder=R[W-1:0], then -> DONE.
- DONE: Done=1 for exactly one cycle, Busy=1; next edge -> IDLE, Busy=0, Done=0.
- Latency:
  - Normal: Done is high in the cycle after edge E0+WIDTH (WIDTH+1 cycles after Run sampled).
  - Error path: Done is high in the cycle after E0.
- Run while Busy (including the DONE cycle) is ignored; no queueing. Back-to-back ops need Run held or re-asserted in IDLE.
- Operand inputs may change freely after E0.
- Flags clear on the next accepted Run.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Dividend and Divisor are two's complement.
  - Core divides magnitudes.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Overflow is also set when the signed quotient is outside [-2^(W-1), 2^(W-1)-1].
  - Sign fix-up is applied on entry to DONE; latency is unchanged.
- Undefined: unsigned only, as described above.

Test Plan:
- Dividend=1000, Divisor=7, Run pulse -> Done in the cycle after E0+16; Quotient=142 (0x008E), Remainder=6, flags 0.
- Dividend=0xFFFE0001, Divisor=0xFFFF -> Quotient=0xFFFF, Remainder=0x0000, Overflow=0.
- Dividend=5, Divisor=0 -> Done in the cycle after E0; DivZero=1, Quotient=0xFFFF, Remainder=0x0005. Dividend=0x12345678, Divisor=0x1234 -> Overflow=1.
- Run re-pulsed at E0+5 with different operands -> ignored; first result unchanged; one Done pulse only.
- Reset low at E0+8 -> outputs 0 asynchronously, state IDLE, no Done; a new Run of 1000/7 after release yields 142 r 6.
- SEQ_DIVIDER_SIGNED_EN: Dividend=-1000, Divisor=7 -> Quotient=0xFF72 (-142), Remainder=0xFFFA (-6). Dividend=0x00008000, Divisor=1 -> Overflow=1.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Optional two's-complement mode via `define SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               overflow
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic             busy_d, done_d, dz_d, ov_d;

  logic [DW-1:0]    dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             negq_in, negr_in;
  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] r_step, q_step, q_fix, r_fix;
  logic             ov_fix;

  // Operand magnitudes and result signs presented to the unsigned core
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvd_mag = dividend[DW-1] ? DW'(-dividend) : dividend;
    dvs_mag = divisor[WIDTH-1] ? WIDTH'(-divisor) : divisor;
    negq_in = dividend[DW-1] ^ divisor[WIDTH-1];
    negr_in = dividend[DW-1];
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
    negq_in = 1'b0;
    negr_in = 1'b0;
`endif
  end

  // One restoring step plus the sign fix-up applied as the result is latched
  always_comb begin
    t      = {r_q, q_q[WIDTH-1]};
    ge     = (t >= {1'b0, dvs_q});
    r_step = ge ? WIDTH'(t - {1'b0, dvs_q}) : t[WIDTH-1:0];
    q_step = {q_q[WIDTH-2:0], ge};
    q_fix  = negq_q ? WIDTH'(-q_step) : q_step;
    r_fix  = negr_q ? WIDTH'(-r_step) : r_step;
`ifdef SEQ_DIVIDER_SIGNED_EN
    ov_fix = negq_q ? (q_step > MIN_MAG) : q_step[WIDTH-1];
`else
    ov_fix = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quotient;
    rem_d   = remainder;
    busy_d  = busy;
    done_d  = 1'b0;
    dz_d    = div_zero;
    ov_d    = overflow;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          busy_d = 1'b1;
          dz_d   = 1'b0;
          ov_d   = 1'b0;
          dvs_d  = dvs_mag;
          negq_d = negq_in;
          negr_d = negr_in;
          cnt_d  = '0;
          if (dvs_mag == '0) begin
            dz_d    = 1'b1;
            quot_d  = '1;
            rem_d   = dividend[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (dvd_mag[DW-1:WIDTH] >= dvs_mag) begin
            ov_d    = 1'b1;
            quot_d  = '1;
            rem_d   = dividend[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            r_d     = dvd_mag[DW-1:WIDTH];
            q_d     = dvd_mag[WIDTH-1:0];
            quot_d  = '0;
            rem_d   = '0;
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_d  = ov_fix ? '1 : q_fix;
          rem_d   = r_fix;
          ov_d    = ov_fix;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      dvs_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      dvs_q     <= dvs_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      quotient  <= quot_d;
      remainder <= rem_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= dz_d;
      overflow  <= ov_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (unsigned build, or signed with SEQ_DIVIDER_SIGNED_EN).
module tb_seq_divider;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           run = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic [W-1:0]   quotient, remainder;
  logic           busy, done, div_zero, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dz;
    logic           ov;
    int             lat;
  } vec_t;

  vec_t vecs[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called #1 after an edge; returns edges after E0 until done is seen (100 = timeout)
  task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int lat);
    dividend = dvd;
    divisor  = dvs;
    run      = 1'b1;
    @(posedge clk); #1;
    run      = 1'b0;
    dividend = 32'hA5A5_5A5A;
    divisor  = 16'h3C3C;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] pq, pr;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{32'hFFFF_FC18, 16'h0007, 16'hFF72, 16'hFFFA, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0000_03E8, 16'hFFF9, 16'hFF72, 16'h0006, 1'b0, 1'b0, 16});
    vecs.push_back('{32'hFFFF_FC18, 16'hFFF9, 16'h008E, 16'hFFFA, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0000_8000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16});
    vecs.push_back('{32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0000_0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 0});
    vecs.push_back('{32'h1234_5678, 16'h1234, 16'hFFFF, 16'h5678, 1'b0, 1'b1, 0});
`else
    vecs.push_back('{32'h0000_03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 1'b0, 16});
    vecs.push_back('{32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0000_0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 0});
    vecs.push_back('{32'h1234_5678, 16'h1234, 16'hFFFF, 16'h5678, 1'b0, 1'b1, 0});
    vecs.push_back('{32'h0000_0000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0000_FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0000_0064, 16'h000A, 16'h000A, 16'h0000, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0001_0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h0001_0003, 16'h0002, 16'h8001, 16'h0001, 1'b0, 1'b0, 16});
`endif

    // Reset state
    #12;
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({div_zero, overflow}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("v%0d_div_zero", i), 32'(div_zero), 32'(vecs[i].dz));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'({busy, done}), 32'd0);
      chk($sformatf("v%0d_hold_q", i), 32'(quotient), 32'(vecs[i].q));
    end

    // Run re-pulsed at E0+5 with other operands must be ignored
    dividend = 32'd1000;
    divisor  = 16'd7;
    run      = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    pulses = 0;
    pq = '0;
    pr = '0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) begin
        run      = 1'b1;
        dividend = 32'd50;
        divisor  = 16'd3;
      end
      if (i == 6) run = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        pq = quotient;
        pr = remainder;
      end
    end
    chk("repulse_done_count", 32'(pulses), 32'd1);
    chk("repulse_quotient", 32'(pq), 32'h008E);
    chk("repulse_remainder", 32'(pr), 32'h0006);
    chk("repulse_hold", 32'(quotient), 32'h008E);

    // Asynchronous reset at E0+8 aborts the divide
    dividend = 32'd1000;
    divisor  = 16'd7;
    run      = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    run_op(32'd1000, 16'd7, lat);
    chk("post_reset_latency", 32'(lat), 32'd16);
`ifdef SEQ_DIVIDER_SIGNED_EN
    chk("post_reset_quotient", 32'(quotient), 32'h008E);
`else
    chk("post_reset_quotient", 32'(quotient), 32'd142);
`endif
    chk("post_reset_remainder", 32'(remainder), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
